// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, opcodes and ALU encodings for the multicycle MIPS controller
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// rtl/mips_aludec.sv - combinational aluop/funct to alucontrol decoder
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  // Unknown funct codes fall back to add so a bad R-type is harmless.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS main controller with memory-ready stalls
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic        pcen,
  output logic [2:0]  alucontrol
);

  state_t state_q, state_d, dec_state;
  aluop_t aluop;
  logic   pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // During reset the outputs present the FETCH decode regardless of the stale state.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regdst = 1'b0;
    memtoreg = 1'b0; regwrite = 1'b0; alusrca = 1'b0; alusrcb = 2'b00;
    pcsrc = 2'b00; pcwrite = 1'b0; branch = 1'b0; aluop = ALUOP_ADD;
    case (dec_state)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero);

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - scoreboard bench for the multicycle MIPS controller
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
  } ctl_t;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  ctl_t  exp_q[$];
  string name_q[$];
  int    checks = 0, failures = 0;
  logic [5:0] cur_op = 6'd0, cur_funct = 6'd0;

  mips_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  function automatic ctl_t idle();
    ctl_t e;
    e = '0;
    e.alucontrol = 3'b010;
    return e;
  endfunction

  function automatic logic [2:0] ref_rtype(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus plus the outputs the model predicts for that clock.
  task automatic cyc(input logic rst, input logic rdy, input logic z, input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = rdy; zero = z; op = cur_op; funct = cur_funct;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic stall_cycles(input int n, input ctl_t e, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rb(), e, nm);
  endtask

  // Behavioural model: the sequence of control words one instruction produces.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fst, input int mst, input logic bz);
    ctl_t e;
    cur_op = o; cur_funct = f;
    e = idle(); e.alusrcb = 2'b01;
    stall_cycles(fst, e, "fetch_stall");
    e.irwrite = 1'b1; e.pcen = 1'b1;
    cyc(1'b0, 1'b1, rb(), e, "fetch");
    e = idle(); e.alusrcb = 2'b11;
    cyc(1'b0, rb(), rb(), e, "decode");
    if (o == T_LW || o == T_SW) begin
      e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
      cyc(1'b0, rb(), rb(), e, "memadr");
      e = idle(); e.iord = 1'b1; e.memwrite = (o == T_SW);
      stall_cycles(mst, e, (o == T_SW) ? "memwr_stall" : "memrd_stall");
      cyc(1'b0, 1'b1, rb(), e, (o == T_SW) ? "memwr" : "memrd");
      if (o == T_LW) begin
        e = idle(); e.memtoreg = 1'b1; e.regwrite = 1'b1;
        cyc(1'b0, rb(), rb(), e, "memwb");
      end
    end else if (o == T_R) begin
      e = idle(); e.alusrca = 1'b1; e.alucontrol = ref_rtype(f);
      cyc(1'b0, rb(), rb(), e, "rtypeex");
      e = idle(); e.regdst = 1'b1; e.regwrite = 1'b1;
      cyc(1'b0, rb(), rb(), e, "rtypewb");
    end else if (o == T_BEQ) begin
      e = idle(); e.alusrca = 1'b1; e.pcsrc = 2'b01; e.alucontrol = 3'b110; e.pcen = bz;
      cyc(1'b0, rb(), bz, e, "beqex");
    end else if (o == T_ADDI) begin
      e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
      cyc(1'b0, rb(), rb(), e, "addiex");
      e = idle(); e.regwrite = 1'b1;
      cyc(1'b0, rb(), rb(), e, "addiwb");
    end else if (o == T_J) begin
      e = idle(); e.pcsrc = 2'b10; e.pcen = 1'b1;
      cyc(1'b0, rb(), rb(), e, "jex");
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e, g;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      g = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", nm, g, e);
      end
    end
  end

  initial begin
    ctl_t rst_e;
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    ops = '{T_LW, T_SW, T_R, T_BEQ, T_ADDI, T_J, 6'b111111};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
    rst_e = idle(); rst_e.alusrcb = 2'b01;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, rst_e, "reset");

    run_instr(T_LW, 6'h00, 0, 0, 1'b0);
    run_instr(T_SW, 6'h00, 0, 2, 1'b0);
    run_instr(T_BEQ, 6'h00, 0, 0, 1'b1);
    run_instr(T_BEQ, 6'h00, 0, 0, 1'b0);
    run_instr(T_R, 6'b101010, 0, 0, 1'b0);
    run_instr(T_R, 6'b000000, 1, 0, 1'b0);
    run_instr(6'b111111, 6'h00, 0, 0, 1'b0);
    run_instr(T_ADDI, 6'h00, 2, 0, 1'b0);
    run_instr(T_J, 6'h00, 0, 0, 1'b0);

    // Abort a load while it waits in MEMRD.
    cur_op = T_LW; cur_funct = 6'h00;
    begin
      ctl_t e;
      e = idle(); e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, e, "abort_fetch");
      e = idle(); e.alusrcb = 2'b11;
      cyc(1'b0, 1'b1, 1'b0, e, "abort_decode");
      e = idle(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
      cyc(1'b0, 1'b0, 1'b0, e, "abort_memadr");
      e = idle(); e.iord = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, e, "abort_memrd");
      cyc(1'b1, 1'b1, 1'b0, rst_e, "abort_reset");
    end
    run_instr(T_ADDI, 6'h00, 1, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 6'b111111) begin
        do o = 6'($urandom);
        while (o == T_LW || o == T_SW || o == T_R || o == T_BEQ || o == T_ADDI || o == T_J);
      end
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
